tdm_slot_config_loader: RTL and testbench
=========================================

Name: tdm_slot_config_loader

Overview:
- Receives TDM configuration messages from the best-effort NoC and serialises them into slot-table and link-enable writes for the NI TDM channel block.
- Drives lut_conf_* and link_en_valid; this is the writer side of those interfaces.
- After each message, returns one response flit to the source tile with the write count and an error flag.
- Sits in the NI next to the TDM channel block, in the NoC clock domain.

Parameters:
- FLIT_WIDTH, 32, flit width; fixed at 32.
- CHANNELS, 4, TDM endpoints per NI; 1..16.
- CT_LINKS, 2, TDM links per NI.
- LUT_SIZE, 8, slots per slot table; must be ≥ CT_LINKS and ≤ 256.
- CONF_CLASS, 3, 3-bit message class accepted as configuration.
- LUT_PORTS, max(CHANNELS, 2*CT_LINKS), local parameter: number of slot tables addressable by sel.

Ports:
- clk  in  1  NoC clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  32  BE ingress flit.
- in_valid  in  1  ingress valid.
- in_last  in  1  last flit of message.
- in_ready  out  1  ingress ready; a flit transfers when in_valid & in_ready.
- out_flit  out  32  response flit.
- out_valid  out  1  response valid.
- out_last  out  1  response last; always equals out_valid.
- out_ready  in  1  response ready.
- lut_conf_data  out  $clog2(CHANNELS+1)  channel written to the slot; the value CHANNELS means idle.
- lut_conf_sel  out  $clog2(LUT_PORTS)  slot table index, or channel index for link enables.
- lut_conf_slot  out  $clog2(LUT_SIZE)  slot index, or link index for link enables.
- lut_conf_valid  out  1  one-cycle slot-table write strobe.
- link_en_valid  out  1  one-cycle link-enable write strobe; lut_conf_data[0] carries the enable value.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1; counters and error flag cleared. A reset mid-message abandons the message silently, with no response and no partial strobe.
- Header flit format: [26:24] class; [20:16] source tile id, latched as response destination; other bits ignored.
- Entry flit format: [31] type (0 = LUT write, 1 = link enable); [23:16] slot; [11:8] sel; [4:0] data.
- IDLE: accept one flit as the header.
  - Class ≠ CONF_CLASS: go to DRAIN, or stay in IDLE if in_last.
  - Class matches and in_last: go to RESP with count=0.
  - Otherwise go to ENTRY.
- ENTRY: accept at most one entry per cycle (in_ready=1). An entry is valid if:
  - type 0: slot < LUT_SIZE, sel < LUT_PORTS, data ≤ CHANNELS;
  - type 1: sel < CHANNELS, slot < CT_LINKS, data ≤ 1.
- Valid entry: the cycle after acceptance, lut_conf_sel/slot/data are registered and exactly one of lut_conf_valid / link_en_valid is pulsed for one cycle; count increments, saturating at 255.
- Invalid entry: no strobe, error flag set.
- Back-to-back entries give back-to-back strobes (1-cycle latency, full throughput). Address/data outputs hold their last value when no strobe is active.
- Entry with in_last: go to RESP; its strobe, if any, fires in the first RESP cycle.
- DRAIN: consume flits with no strobes; return to IDLE on in_last. No response is sent.
- RESP: in_ready=0.
  - out_flit = {src_id[31:27], CONF_CLASS[26:24], 8'b0, count[15:8], 7'b0, err[0]}; out_valid=1, out_last=1.
  - out_valid stays high and out_flit stays stable until out_ready, so out_ready held low stalls indefinitely.
  - On transfer: clear count and err, go to IDLE.
- Out-of-range fields are never truncated into a legal write; they only raise err.

Optional Feature:
- Macro TDM_CONF_LOCK_EN.
- When defined: adds input conf_lock (1 bit). While conf_lock=1, every entry in ENTRY is treated as invalid (no strobe, err set). conf_lock is sampled per accepted entry.
- When undefined: no port, no lock logic; behaviour as above.

Test Plan:
- Header class 3, src 5; entries LUT sel=1 slot=2 data=3 and link-enable sel=2 slot=1 data=1, last on the second entry → lut_conf_valid with (1,2,3) one cycle after the first entry; link_en_valid with (2,1,1) next; response 0x2B00_0200.
- Header class 2 followed by 3 flits, last on the third → no strobes, no response, in_ready=1 throughout, back in IDLE.
- Entries slot=8, then sel=4 with data=5, then a valid entry → one strobe only; response count=1, err=1.
- Header with in_last, out_ready held 0 for 10 cycles → out_valid high and stable for 10 cycles, in_ready=0; response count=0 on release.
- 300 valid entries → response count field 0xFF; rst asserted mid-message → busy=0 and no response next cycle.
- With TDM_CONF_LOCK_EN and conf_lock=1 on 2 entries → no strobes; response count=0, err=1.

Source files
------------

// File: rtl/tdm_slot_config_loader.sv
// tdm_slot_config_loader
//   Takes TDM configuration messages from the best-effort NoC and turns them
//   into slot-table writes (lut_conf_*) and link-enable writes (link_en_valid)
//   for the NI TDM channel block. One response flit goes back to the source
//   tile after each configuration message. It carries the write count and an
//   error flag.
//
//   Optional feature: define TDM_CONF_LOCK_EN to add the conf_lock input.
//   While conf_lock is high, every entry is rejected.
//
// Ports
//   clk, rst          NoC clock, synchronous active-high reset
//   conf_lock         (TDM_CONF_LOCK_EN only) reject all entries while high
//   in_flit/valid/last/ready     BE ingress stream
//   out_flit/valid/last/ready    response stream (out_last == out_valid)
//   lut_conf_data/sel/slot       registered write address/data
//   lut_conf_valid    one-cycle slot-table write strobe
//   link_en_valid     one-cycle link-enable strobe (enable in lut_conf_data[0])
//   busy              high whenever the FSM is not idle
module tdm_slot_config_loader #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CT_LINKS   = 2,
  parameter int unsigned LUT_SIZE   = 8,
  parameter logic [2:0]  CONF_CLASS = 3'd3,
  localparam int unsigned LUT_PORTS = (CHANNELS > 2*CT_LINKS) ? CHANNELS : 2*CT_LINKS,
  localparam int unsigned DATA_W    = $clog2(CHANNELS+1),
  localparam int unsigned SEL_W     = (LUT_PORTS > 1) ? $clog2(LUT_PORTS) : 1,
  localparam int unsigned SLOT_W    = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TDM_CONF_LOCK_EN
  input  logic                  conf_lock,
`endif
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     lut_conf_data,
  output logic [SEL_W-1:0]      lut_conf_sel,
  output logic [SLOT_W-1:0]     lut_conf_slot,
  output logic                  lut_conf_valid,
  output logic                  link_en_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ENTRY, DRAIN, RESP} state_t;

  state_t      state, state_nx;
  logic [4:0]  src_id;
  logic [7:0]  count;
  logic        err;

  logic        hs_in, hs_out;
  logic [2:0]  hdr_class;
  logic [4:0]  hdr_src;
  logic        ent_type;
  logic [31:0] ent_slot, ent_sel, ent_data;
  logic        lut_ok, link_ok, lock, entry_ok;
  logic        unused_bits;

  assign hdr_class = in_flit[26:24];
  assign hdr_src   = in_flit[20:16];
  assign ent_type  = in_flit[31];
  assign ent_slot  = 32'(in_flit[23:16]);
  assign ent_sel   = 32'(in_flit[11:8]);
  assign ent_data  = 32'(in_flit[4:0]);
  assign unused_bits = ^{in_flit[30:27], in_flit[15:12], in_flit[7:5]};

`ifdef TDM_CONF_LOCK_EN
  assign lock = conf_lock;
`else
  assign lock = 1'b0;
`endif

  // Checked against the full flit fields so out-of-range values can never
  // alias onto a legal address after truncation.
  assign lut_ok   = !ent_type && (ent_slot < LUT_SIZE) && (ent_sel < LUT_PORTS)
                    && (ent_data <= CHANNELS);
  assign link_ok  = ent_type && (ent_sel < CHANNELS) && (ent_slot < CT_LINKS)
                    && (ent_data <= 32'd1);
  assign entry_ok = (lut_ok || link_ok) && !lock;

  assign hs_in  = in_valid && in_ready;
  assign hs_out = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (in_valid) begin
          if (hdr_class != CONF_CLASS) state_nx = in_last ? IDLE : DRAIN;
          else                         state_nx = in_last ? RESP : ENTRY;
        end
      end
      ENTRY: if (in_valid && in_last) state_nx = RESP;
      DRAIN: if (in_valid && in_last) state_nx = IDLE;
      RESP: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_last = out_valid;
  assign out_flit = out_valid ? {src_id, CONF_CLASS, 8'b0, count, 7'b0, err} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_id         <= '0;
      count          <= '0;
      err            <= 1'b0;
      lut_conf_data  <= '0;
      lut_conf_sel   <= '0;
      lut_conf_slot  <= '0;
      lut_conf_valid <= 1'b0;
      link_en_valid  <= 1'b0;
    end else begin
      lut_conf_valid <= 1'b0;
      link_en_valid  <= 1'b0;
      if (state == IDLE && hs_in) begin
        src_id <= hdr_src;
        count  <= '0;
        err    <= 1'b0;
      end
      if (state == ENTRY && hs_in) begin
        if (entry_ok) begin
          lut_conf_sel   <= SEL_W'(ent_sel);
          lut_conf_slot  <= SLOT_W'(ent_slot);
          lut_conf_data  <= DATA_W'(ent_data);
          lut_conf_valid <= !ent_type;
          link_en_valid  <= ent_type;
          if (count != 8'hFF) count <= count + 8'd1;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == RESP && hs_out) begin
        count <= '0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_slot_config_loader.sv
// Directed self-checking bench for tdm_slot_config_loader (default parameters:
// CHANNELS=4, CT_LINKS=2, LUT_SIZE=8, CONF_CLASS=3).
module tb_tdm_slot_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        conf_lock = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [2:0]  lut_conf_data;
  logic [1:0]  lut_conf_sel;
  logic [2:0]  lut_conf_slot;
  logic        lut_conf_valid;
  logic        link_en_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_slot_config_loader #(
    .FLIT_WIDTH(32), .CHANNELS(4), .CT_LINKS(2), .LUT_SIZE(8), .CONF_CLASS(3'd3)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef TDM_CONF_LOCK_EN
    .conf_lock(conf_lock),
`endif
    .in_flit(in_flit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .lut_conf_data(lut_conf_data), .lut_conf_sel(lut_conf_sel),
    .lut_conf_slot(lut_conf_slot), .lut_conf_valid(lut_conf_valid),
    .link_en_valid(link_en_valid), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] f, input logic last);
    in_flit  = f;
    in_valid = 1'b1;
    in_last  = last;
    tick();
  endtask

  task automatic chk_wr(input string tag, input logic lut, input logic link,
                        input logic [31:0] sel, input logic [31:0] slot,
                        input logic [31:0] data);
    chk({tag, "_lutv"}, 32'(lut_conf_valid), 32'(lut));
    chk({tag, "_linkv"}, 32'(link_en_valid), 32'(link));
    chk({tag, "_sel"}, 32'(lut_conf_sel), sel);
    chk({tag, "_slot"}, 32'(lut_conf_slot), slot);
    chk({tag, "_data"}, 32'(lut_conf_data), data);
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_flit", out_flit, 32'h0);
    chk_wr("rst", 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // basic message: LUT write then link enable
    send(32'h0305_0000, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send(32'h0002_0103, 1'b0);
    chk_wr("t1_e1", 1'b1, 1'b0, 1, 2, 3);
    send(32'h8001_0201, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk_wr("t1_e2", 1'b0, 1'b1, 2, 1, 1);
    chk("t1_resp_valid", 32'(out_valid), 32'd1);
    chk("t1_resp_last", 32'(out_last), 32'd1);
    chk("t1_resp_in_ready", 32'(in_ready), 32'd0);
    chk("t1_resp_flit", out_flit, 32'h2B00_0200);
    tick();
    chk_wr("t1_hold", 1'b0, 1'b0, 2, 1, 1);
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_done_valid", 32'(out_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // non-config class is drained silently
    send(32'h0205_0000, 1'b0);
    chk("t2_drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_in_ready", 32'(in_ready), 32'd1);
      send(32'h0002_0103, i == 2);
      chk("t2_no_lut", 32'(lut_conf_valid), 32'd0);
      chk("t2_no_link", 32'(link_en_valid), 32'd0);
      chk("t2_no_resp", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t2_idle", 32'(busy), 32'd0);
    tick();
    chk("t2_still_no_resp", 32'(out_valid), 32'd0);

    // invalid entries raise err and produce no strobe
    send(32'h0305_0000, 1'b0);
    send(32'h0008_0000, 1'b0);      // slot 8 out of range
    chk_wr("t3_slot8", 1'b0, 1'b0, 2, 1, 1);
    send(32'h0000_0405, 1'b0);      // sel 4, data 5
    chk_wr("t3_sel4", 1'b0, 1'b0, 2, 1, 1);
    send(32'h8002_0101, 1'b0);      // link index 2 out of range
    chk_wr("t3_link2", 1'b0, 1'b0, 2, 1, 1);
    send(32'h0007_0304, 1'b1);      // boundary-valid: slot 7, sel 3, data 4
    in_valid = 1'b0; in_last = 1'b0;
    chk_wr("t3_ok", 1'b1, 1'b0, 3, 7, 4);
    chk("t3_resp_flit", out_flit, 32'h2B00_0101);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_done_valid", 32'(out_valid), 32'd0);

    // header-only message with a stalled response
    send(32'h031F_0000, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_flit", out_flit, 32'hFB00_0000);
      chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_done_valid", 32'(out_valid), 32'd0);
    chk("t4_done_busy", 32'(busy), 32'd0);

    // count saturation
    send(32'h0305_0000, 1'b0);
    for (int i = 0; i < 300; i++) begin
      send(32'(i % 8) << 16, i == 299);
      chk("t5_lutv", 32'(lut_conf_valid), 32'd1);
      chk("t5_slot", 32'(lut_conf_slot), 32'(i % 8));
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5_resp_flit", out_flit, 32'h2B00_FF00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset in the middle of a message
    send(32'h0305_0000, 1'b0);
    send(32'h0001_0102, 1'b0);
    send(32'h0002_0203, 1'b0);
    chk("t5r_pre_lutv", 32'(lut_conf_valid), 32'd1);
    rst = 1'b1;
    send(32'h0003_0301, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5r_busy", 32'(busy), 32'd0);
    chk("t5r_in_ready", 32'(in_ready), 32'd1);
    chk_wr("t5r", 1'b0, 1'b0, 0, 0, 0);
    tick();
    chk("t5r_no_resp", 32'(out_valid), 32'd0);
    chk("t5r_no_strobe", 32'(lut_conf_valid | link_en_valid), 32'd0);

`ifdef TDM_CONF_LOCK_EN
    conf_lock = 1'b1;
    send(32'h0305_0000, 1'b0);
    send(32'h0002_0103, 1'b0);
    chk("t6_no_lut", 32'(lut_conf_valid), 32'd0);
    send(32'h8001_0201, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t6_no_link", 32'(link_en_valid), 32'd0);
    chk("t6_resp_flit", out_flit, 32'h2B00_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    conf_lock = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
